// File: rtl/uart_hash_pkg.sv
// uart_hash_pkg: shared types and constants for the UART hash command front-end.
// Holds the FSM state encoding, command/response characters and frame sizing.
package uart_hash_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        CHECK,
        ISSUE,
        HASHING,
        SEND
    } state_t;

    localparam logic [7:0] CMD_H = "H";
    localparam logic [7:0] CMD_L = "L";
    localparam logic [7:0] CMD_S = "S";
    localparam logic [7:0] CMD_A = "A";

    localparam logic [7:0] RSP_1 = "1";
    localparam logic [7:0] RSP_0 = "0";
    localparam logic [7:0] RSP_2 = "2";
    localparam logic [7:0] RSP_K = "K";
    localparam logic [7:0] RSP_C = "C";
    localparam logic [7:0] RSP_T = "T";
    localparam logic [7:0] RSP_E = "E";
    localparam logic [7:0] RSP_B = "B";
    localparam logic [7:0] RSP_A = "A";
    localparam logic [7:0] RSP_Y = "Y";
    localparam logic [7:0] RSP_N = "N";

    // Payload bytes of a LOAD frame: data, midstate, target, nonce base, position.
    function automatic int load_bytes(input int d, input int s,
                                      input int t, input int n);
        return d + s + t + n + 4;
    endfunction

endpackage

// File: rtl/uart_hash_resp_ser.sv
// uart_hash_resp_ser: serialises one response byte or a 'Y' result frame
// onto the tx byte stream, one byte outstanding, and flags the last handshake.
module uart_hash_resp_ser
    import uart_hash_pkg::*;
#(
    parameter int NONCE_BYTES  = 4,
    parameter int DIGEST_BYTES = 32,
    parameter bit SEND_DIGEST  = 1'b0
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      load,
    input  logic                      load_y,
    input  logic [7:0]                rsp_byte,
    input  logic [8*NONCE_BYTES-1:0]  nonce,
    input  logic [8*DIGEST_BYTES-1:0] digest,
    output logic                      tx_valid,
    output logic [7:0]                tx_data,
    input  logic                      tx_ready,
    output logic                      done
);

    localparam int FB = 1 + NONCE_BYTES + (SEND_DIGEST ? DIGEST_BYTES : 0);
    localparam int SW = 8 * (1 + NONCE_BYTES + DIGEST_BYTES);
    localparam int CW = $clog2(FB + 1);

    logic [SW-1:0] sh;
    logic [CW-1:0] left;

    assign tx_data = sh[7:0];
    assign done    = tx_valid && tx_ready && (left == CW'(1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sh       <= '0;
            left     <= '0;
            tx_valid <= 1'b0;
        end else if (load) begin
            tx_valid <= 1'b1;
            if (load_y) begin
                sh   <= {digest, nonce, RSP_Y};
                left <= CW'(FB);
            end else begin
                sh   <= SW'(rsp_byte);
                left <= CW'(1);
            end
        end else if (tx_valid && tx_ready) begin
            sh   <= sh >> 8;
            left <= left - CW'(1);
            if (left == CW'(1))
                tx_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_hash_ctrl.sv
// uart_hash_ctrl: framed UART command front-end for a double-SHA256 search core.
// Parses commands, loads and issues jobs, and reports status, abort and results.
module uart_hash_ctrl
    import uart_hash_pkg::*;
#(
    parameter int DATA_BYTES   = 64,
    parameter int STATE_BYTES  = 32,
    parameter int TARGET_BYTES = 32,
    parameter int NONCE_BYTES  = 4,
    parameter int DIGEST_BYTES = 32,
    parameter bit SEND_DIGEST  = 1'b0,
    parameter int TIMEOUT_CYC  = 1_000_000
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_data,
    output logic                      rx_ready,
    output logic                      tx_valid,
    output logic [7:0]                tx_data,
    input  logic                      tx_ready,
    output logic                      job_valid,
    input  logic                      job_ready,
    output logic [8*DATA_BYTES-1:0]   job_data,
    output logic [8*STATE_BYTES-1:0]  job_state,
    output logic [8*TARGET_BYTES-1:0] job_target,
    output logic [8*NONCE_BYTES-1:0]  job_nonce_base,
    output logic [31:0]               job_position,
    output logic                      core_abort,
    input  logic                      result_valid,
    input  logic                      result_found,
    input  logic [8*NONCE_BYTES-1:0]  result_nonce,
    input  logic [8*DIGEST_BYTES-1:0] result_digest,
    output logic                      busy
);

    localparam int LB    = load_bytes(DATA_BYTES, STATE_BYTES,
                                      TARGET_BYTES, NONCE_BYTES);
    localparam int PW    = 8 * LB;
    localparam int CW    = $clog2(LB + 1);
    localparam int OFS_S = 8 * DATA_BYTES;
    localparam int OFS_T = OFS_S + 8 * STATE_BYTES;
    localparam int OFS_N = OFS_T + 8 * TARGET_BYTES;
    localparam int OFS_P = OFS_N + 8 * NONCE_BYTES;

    state_t                    state;
    logic [PW-1:0]             pl;
    logic [CW-1:0]             cnt;
    logic [7:0]                csum;
    logic [7:0]                csum_rx;
    logic [31:0]               tmo;
    logic                      rsp_go;
    logic                      rsp_y;
    logic [7:0]                rsp_byte;
    logic                      rsp_done;
    logic                      sent;
    logic                      res_found;
    logic [8*NONCE_BYTES-1:0]  res_nonce;
    logic [8*DIGEST_BYTES-1:0] res_digest;
    logic                      acc;

    assign acc = rx_valid && rx_ready;

    // Payload shifts in from the top, so byte 0 ends up at bit 0.
    assign job_data       = pl[0 +: 8*DATA_BYTES];
    assign job_state      = pl[OFS_S +: 8*STATE_BYTES];
    assign job_target     = pl[OFS_T +: 8*TARGET_BYTES];
    assign job_nonce_base = pl[OFS_N +: 8*NONCE_BYTES];
    assign job_position   = pl[OFS_P +: 32];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            pl         <= '0;
            cnt        <= '0;
            csum       <= '0;
            csum_rx    <= '0;
            tmo        <= '0;
            rsp_go     <= 1'b0;
            rsp_y      <= 1'b0;
            rsp_byte   <= '0;
            sent       <= 1'b0;
            res_found  <= 1'b0;
            res_nonce  <= '0;
            res_digest <= '0;
            rx_ready   <= 1'b0;
            job_valid  <= 1'b0;
            core_abort <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rsp_go     <= 1'b0;
            rsp_y      <= 1'b0;
            core_abort <= 1'b0;
            // Accept input only while no response is queued or in flight.
            rx_ready   <= !((tx_valid && !rsp_done) || rsp_go);
            case (state)
                IDLE: if (acc) begin
                    unique case (1'b1)
                        rx_data == CMD_H:
                            {rsp_go, rsp_byte, rx_ready} <= {1'b1, RSP_1, 1'b0};
                        rx_data == CMD_S:
                            {rsp_go, rsp_byte, rx_ready} <= {1'b1, RSP_0, 1'b0};
                        rx_data == CMD_A:
                            {rsp_go, rsp_byte, rx_ready} <= {1'b1, RSP_A, 1'b0};
                        rx_data == CMD_L: begin
                            state <= RECV;
                            cnt   <= '0;
                            csum  <= '0;
                            tmo   <= '0;
                        end
                        default:
                            {rsp_go, rsp_byte, rx_ready} <= {1'b1, RSP_E, 1'b0};
                    endcase
                end
                RECV: if (acc) begin
                    tmo <= '0;
                    if (cnt == CW'(LB)) begin
                        csum_rx  <= rx_data;
                        rx_ready <= 1'b0;
                        state    <= CHECK;
                    end else begin
                        pl   <= {rx_data, pl[PW-1:8]};
                        csum <= csum ^ rx_data;
                        cnt  <= cnt + CW'(1);
                    end
                end else if (TIMEOUT_CYC != 0 && tmo == 32'(TIMEOUT_CYC - 1)) begin
                    {rsp_go, rsp_byte, rx_ready} <= {1'b1, RSP_T, 1'b0};
                    state <= IDLE;
                end else begin
                    tmo <= tmo + 32'd1;
                end
                CHECK: if (csum == csum_rx) begin
                    {rsp_go, rsp_byte, rx_ready} <= {1'b1, RSP_K, 1'b0};
                    job_valid <= 1'b1;
                    busy      <= 1'b1;
                    state     <= ISSUE;
                end else begin
                    {rsp_go, rsp_byte, rx_ready} <= {1'b1, RSP_C, 1'b0};
                    state <= IDLE;
                end
                ISSUE: begin
                    if (job_ready) begin
                        job_valid <= 1'b0;
                        state     <= HASHING;
                    end
                    if (acc) begin
                        unique case (1'b1)
                            rx_data == CMD_S:
                                {rsp_go, rsp_byte, rx_ready} <= {1'b1, RSP_1, 1'b0};
                            rx_data == CMD_A: begin
                                {rsp_go, rsp_byte, rx_ready} <= {1'b1, RSP_A, 1'b0};
                                // Job taken this very cycle: the core must drop it.
                                core_abort <= job_ready;
                                job_valid  <= 1'b0;
                                busy       <= 1'b0;
                                state      <= IDLE;
                            end
                            default:
                                {rsp_go, rsp_byte, rx_ready} <= {1'b1, RSP_B, 1'b0};
                        endcase
                    end
                end
                HASHING: if (result_valid) begin
                    res_found  <= result_found;
                    res_nonce  <= result_nonce;
                    res_digest <= result_digest;
                    sent       <= 1'b0;
                    busy       <= 1'b0;
                    rx_ready   <= 1'b0;
                    state      <= SEND;
                end else if (acc) begin
                    unique case (1'b1)
                        rx_data == CMD_S:
                            {rsp_go, rsp_byte, rx_ready} <= {1'b1, RSP_2, 1'b0};
                        rx_data == CMD_A: begin
                            {rsp_go, rsp_byte, rx_ready} <= {1'b1, RSP_A, 1'b0};
                            core_abort <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end
                        default:
                            {rsp_go, rsp_byte, rx_ready} <= {1'b1, RSP_B, 1'b0};
                    endcase
                end
                SEND: begin
                    rx_ready <= 1'b0;
                    if (!sent && !tx_valid && !rsp_go) begin
                        rsp_go   <= 1'b1;
                        rsp_y    <= res_found;
                        rsp_byte <= RSP_N;
                        sent     <= 1'b1;
                    end else if (sent && rsp_done) begin
                        rx_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    uart_hash_resp_ser #(
        .NONCE_BYTES (NONCE_BYTES),
        .DIGEST_BYTES(DIGEST_BYTES),
        .SEND_DIGEST (SEND_DIGEST)
    ) u_ser (
        .clk     (clk),
        .rstn    (rstn),
        .load    (rsp_go),
        .load_y  (rsp_y),
        .rsp_byte(rsp_byte),
        .nonce   (res_nonce),
        .digest  (res_digest),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .tx_ready(tx_ready),
        .done    (rsp_done)
    );

endmodule

// File: tb/tb_uart_hash_ctrl.sv
// tb_uart_hash_ctrl: directed bench for uart_hash_ctrl command/response flow.
// Drives rx bytes and core results, checks tx replies and job/abort outputs.
module tb_uart_hash_ctrl;

    localparam int DB  = 64;
    localparam int SB  = 32;
    localparam int TB  = 32;
    localparam int NB  = 4;
    localparam int GB  = 32;
    localparam int TMO = 64;
    localparam int LB  = DB + SB + TB + NB + 4;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            rx_valid = 1'b0;
    logic [7:0]      rx_data = '0;
    logic            rx_ready;
    logic            tx_valid;
    logic [7:0]      tx_data;
    logic            tx_ready = 1'b0;
    logic            job_valid;
    logic            job_ready = 1'b0;
    logic [8*DB-1:0] job_data;
    logic [8*SB-1:0] job_state;
    logic [8*TB-1:0] job_target;
    logic [8*NB-1:0] job_nonce_base;
    logic [31:0]     job_position;
    logic            core_abort;
    logic            result_valid = 1'b0;
    logic            result_found = 1'b0;
    logic [8*NB-1:0] result_nonce = '0;
    logic [8*GB-1:0] result_digest = '0;
    logic            busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_hash_ctrl #(
        .DATA_BYTES  (DB),
        .STATE_BYTES (SB),
        .TARGET_BYTES(TB),
        .NONCE_BYTES (NB),
        .DIGEST_BYTES(GB),
        .SEND_DIGEST (1'b0),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rx_ready      (rx_ready),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .job_valid     (job_valid),
        .job_ready     (job_ready),
        .job_data      (job_data),
        .job_state     (job_state),
        .job_target    (job_target),
        .job_nonce_base(job_nonce_base),
        .job_position  (job_position),
        .core_abort    (core_abort),
        .result_valid  (result_valid),
        .result_found  (result_found),
        .result_nonce  (result_nonce),
        .result_digest (result_digest),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready)
            chk("rx_hs", 64'(rx_ready), 64'd1);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic get_tx(input string tag, input logic [7:0] exp,
                          input bit rnd);
        bit got = 1'b0;
        for (int n = 0; n < 3000 && !got; n++) begin
            @(negedge clk);
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tx_valid && tx_ready) begin
                chk(tag, 64'(tx_data), 64'(exp));
                got = 1'b1;
            end
        end
        chk({tag, "_hs"}, 64'(got), 64'd1);
        @(posedge clk);
        #1 tx_ready = 1'b0;
    endtask

    task automatic do_load(input bit bad);
        logic [7:0] x = '0;
        send_rx("L");
        for (int i = 0; i < LB; i++) begin
            send_rx(8'(i));
            x ^= 8'(i);
        end
        send_rx(bad ? (x ^ 8'h01) : x);
    endtask

    task automatic hand_job();
        @(negedge clk);
        job_ready = 1'b1;
        @(posedge clk);
        #1 job_ready = 1'b0;
    endtask

    task automatic start_job();
        do_load(1'b0);
        get_tx("sj_k", "K", 1'b0);
        hand_job();
    endtask

    task automatic pulse_result(input bit found, input logic [31:0] nonce);
        @(negedge clk);
        result_valid = 1'b1;
        result_found = found;
        result_nonce = nonce;
        @(posedge clk);
        #1 result_valid = 1'b0;
    endtask

    logic [7:0] cmds[3] = '{"H", "Q", "S"};
    logic [7:0] exps[3] = '{"1", "E", "0"};

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_txv", 64'(tx_valid), 64'd0);
        chk("rst_txd", 64'(tx_data), 64'd0);
        chk("rst_rdy", 64'(rx_ready), 64'd0);
        chk("rst_jv", 64'(job_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_abort", 64'(core_abort), 64'd0);
        chk("rst_pos", 64'(job_position), 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rel_rdy", 64'(rx_ready), 64'd1);

        for (int i = 0; i < 3; i++) begin
            send_rx(cmds[i]);
            @(negedge clk);
            chk("pend_rdy", 64'(rx_ready), 64'd0);
            get_tx("cmd_rsp", exps[i], 1'b0);
        end

        do_load(1'b0);
        get_tx("ld_k", "K", 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("jv_hold", 64'(job_valid), 64'd1);
        end
        chk("busy_issue", 64'(busy), 64'd1);
        hand_job();
        @(negedge clk);
        chk("jv_drop", 64'(job_valid), 64'd0);
        chk("busy_hash", 64'(busy), 64'd1);
        chk("data0", 64'(job_data[7:0]), 64'h00);
        chk("state0", 64'(job_state[7:0]), 64'h40);
        chk("target0", 64'(job_target[7:0]), 64'h60);
        chk("nbase", 64'(job_nonce_base), 64'h83828180);
        chk("pos", 64'(job_position), 64'h87868584);
        send_rx("S");
        get_tx("hash_s", "2", 1'b0);

        pulse_result(1'b1, 32'h11223344);
        get_tx("y_y", "Y", 1'b1);
        get_tx("y_b0", 8'h44, 1'b1);
        get_tx("y_b1", 8'h33, 1'b1);
        get_tx("y_b2", 8'h22, 1'b1);
        get_tx("y_b3", 8'h11, 1'b1);
        chk("y_busy", 64'(busy), 64'd0);
        send_rx("H");
        get_tx("y_idle", "1", 1'b0);

        do_load(1'b1);
        get_tx("bad_c", "C", 1'b0);
        chk("bad_jv", 64'(job_valid), 64'd0);

        send_rx("L");
        for (int i = 0; i < 10; i++)
            send_rx(8'(i));
        get_tx("tmo_t", "T", 1'b0);
        send_rx("H");
        get_tx("tmo_h", "1", 1'b0);

        start_job();
        send_rx("A");
        @(negedge clk);
        chk("abort_hi", 64'(core_abort), 64'd1);
        @(negedge clk);
        chk("abort_lo", 64'(core_abort), 64'd0);
        get_tx("abort_a", "A", 1'b0);
        chk("abort_busy", 64'(busy), 64'd0);

        start_job();
        pulse_result(1'b0, 32'h0);
        get_tx("nf_n", "N", 1'b0);
        send_rx("H");
        get_tx("nf_idle", "1", 1'b0);

        start_job();
        pulse_result(1'b1, 32'h55667788);
        get_tx("rs_y", "Y", 1'b0);
        @(negedge clk);
        chk("rs_pend", 64'(tx_valid), 64'd1);
        rstn = 1'b0;
        @(negedge clk);
        chk("rs_txv", 64'(tx_valid), 64'd0);
        chk("rs_busy", 64'(busy), 64'd0);
        chk("rs_pos", 64'(job_position), 64'd0);
        rstn = 1'b1;
        send_rx("H");
        get_tx("rs_idle", "1", 1'b0);

        start_job();
        @(negedge clk);
        chk("sim_rdy", 64'(rx_ready), 64'd1);
        rx_valid     = 1'b1;
        rx_data      = "S";
        result_valid = 1'b1;
        result_found = 1'b1;
        result_nonce = 32'hA1B2C3D4;
        @(posedge clk);
        #1;
        rx_valid     = 1'b0;
        result_valid = 1'b0;
        get_tx("sim_y", "Y", 1'b0);
        get_tx("sim_b0", 8'hD4, 1'b0);
        get_tx("sim_b1", 8'hC3, 1'b0);
        get_tx("sim_b2", 8'hB2, 1'b0);
        get_tx("sim_b3", 8'hA1, 1'b0);
        repeat (3) @(negedge clk);
        chk("sim_quiet", 64'(tx_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
